// File: rtl/la_scan_ctrl.sv
// Scan-chain test controller: shifts a pattern into a chain, pulses one capture cycle,
// shifts the response back out and compares it against an expected vector.
// The expected-response port is named `expected` because `expect` is a reserved word.
module la_scan_ctrl #(
  parameter int unsigned LEN  = 8,
  parameter string       PROP = "DEFAULT"
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           start,
  input  logic [LEN-1:0] pattern,
  input  logic [LEN-1:0] expected,
  input  logic           so,
  output logic           se,
  output logic           si,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [LEN-1:0] resp
);

  localparam int unsigned     CntW    = $clog2(LEN + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(LEN - 1);
  // Implementation hint only; carried for library compatibility.
  localparam string           prop_unused = PROP;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCapture,
    StUnload,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [LEN-1:0]  pat_q, pat_d;
  logic [LEN-1:0]  exp_q, exp_d;
  logic [LEN-1:0]  resp_q, resp_d;
  logic            pass_q, pass_d;
  logic [LEN-1:0]  resp_shift;

  // so is sampled before the chain moves, so the last cell's capture lands in the MSB.
  assign resp_shift = {resp_q[LEN-2:0], so};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    exp_d   = exp_q;
    resp_d  = resp_q;
    pass_d  = pass_q;
    se      = 1'b0;
    si      = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          pat_d   = pattern;
          exp_d   = expected;
          resp_d  = '0;
          pass_d  = 1'b0;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        se    = 1'b1;
        si    = pat_q[LEN-1];
        // Holding register shifts MSB-first so si never needs a variable index.
        pat_d = {pat_q[LEN-2:0], 1'b0};
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapture: begin
        cnt_d   = '0;
        state_d = StUnload;
      end
      StUnload: begin
        se     = 1'b1;
        resp_d = resp_shift;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          pass_d  = (resp_shift == exp_q);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pat_q   <= '0;
      exp_q   <= '0;
      resp_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      resp_q  <= resp_d;
      pass_q  <= pass_d;
    end
  end

  assign pass = pass_q;
  assign resp = resp_q;

endmodule

// File: tb/tb_la_scan_ctrl.sv
// Bench for la_scan_ctrl: an 8-cell inverting-capture chain and a 2-cell holding chain,
// with expected responses queued at start and checked when done pulses.
module tb_la_scan_ctrl;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // LEN = 8 instance
  logic       start8 = 1'b0;
  logic [7:0] pat8 = '0, exp8 = '0;
  logic       so8, se8, si8, busy8, done8, pass8;
  logic [7:0] resp8;
  logic [7:0] chain8 = '0;

  // LEN = 2 instance
  logic       start2 = 1'b0;
  logic [1:0] pat2 = '0, exp2 = '0;
  logic       so2, se2, si2, busy2, done2, pass2;
  logic [1:0] resp2;
  logic [1:0] chain2 = '0;

  la_scan_ctrl #(.LEN(8), .PROP("DEFAULT")) dut8 (
    .clk(clk), .nreset(nreset), .start(start8), .pattern(pat8), .expected(exp8),
    .so(so8), .se(se8), .si(si8), .busy(busy8), .done(done8), .pass(pass8), .resp(resp8)
  );

  la_scan_ctrl #(.LEN(2), .PROP("DEFAULT")) dut2 (
    .clk(clk), .nreset(nreset), .start(start2), .pattern(pat2), .expected(exp2),
    .so(so2), .se(se2), .si(si2), .busy(busy2), .done(done2), .pass(pass2), .resp(resp2)
  );

  // Chain models: cell 0 is fed by si, so is the last cell. Chain 8 captures ~state,
  // chain 2 captures its own state.
  always @(posedge clk) begin
    if (se8) chain8 <= {chain8[6:0], si8};
    else     chain8 <= ~chain8;
    if (se2) chain2 <= {chain2[0], si2};
  end
  assign so8 = chain8[7];
  assign so2 = chain2[1];

  typedef struct packed { logic [7:0] resp; logic pass; } exp8_t;
  typedef struct packed { logic [1:0] resp; logic pass; } exp2_t;
  exp8_t sb8[$];
  exp2_t sb2[$];
  exp8_t e8;
  exp2_t e2;
  int dones8 = 0;
  int dones2 = 0;

  always @(posedge clk) begin
    #1;
    if (done8 === 1'b1) begin
      dones8++;
      vectors++;
      if (sb8.size() == 0) begin
        miscompares++;
        $display("FAIL sb8_extra_done: got done with resp=%h, want no done", resp8);
      end else begin
        e8 = sb8.pop_front();
        if (resp8 !== e8.resp || pass8 !== e8.pass) begin
          miscompares++;
          $display("FAIL sb8_result: got resp=%h pass=%b, want resp=%h pass=%b",
                   resp8, pass8, e8.resp, e8.pass);
        end
      end
    end
    if (done2 === 1'b1) begin
      dones2++;
      vectors++;
      if (sb2.size() == 0) begin
        miscompares++;
        $display("FAIL sb2_extra_done: got done with resp=%b, want no done", resp2);
      end else begin
        e2 = sb2.pop_front();
        if (resp2 !== e2.resp || pass2 !== e2.pass) begin
          miscompares++;
          $display("FAIL sb2_result: got resp=%b pass=%b, want resp=%b pass=%b",
                   resp2, pass2, e2.resp, e2.pass);
        end
      end
    end
  end

  // Called #1 after a posedge with the DUT idle; returns #1 after the accepting edge.
  task automatic kick8(input logic [7:0] p, input logic [7:0] e, input bit push);
    exp8_t x;
    pat8 = p;
    exp8 = e;
    if (push) begin
      x.resp = ~p;
      x.pass = ((~p) == e);
      sb8.push_back(x);
    end
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
  endtask

  task automatic kick2(input logic [1:0] p, input logic [1:0] e);
    exp2_t x;
    pat2 = p;
    exp2 = e;
    x.resp = p;
    x.pass = (p == e);
    sb2.push_back(x);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({se8, si8, busy8, done8, pass8, resp8} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset8: got se=%b si=%b busy=%b done=%b pass=%b resp=%h, want all 0",
               se8, si8, busy8, done8, pass8, resp8);
    end
    vectors++;
    if ({se2, si2, busy2, done2, pass2, resp2} !== 7'h0) begin
      miscompares++;
      $display("FAIL reset2: got se=%b si=%b busy=%b done=%b pass=%b resp=%b, want all 0",
               se2, si2, busy2, done2, pass2, resp2);
    end
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({se8, busy8, done8} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_after_reset: got se=%b busy=%b done=%b, want 000", se8, busy8, done8);
    end
  endtask

  task automatic test_load_capture;
    logic [7:0] p;
    int n;
    p = 8'hA5;
    kick8(p, 8'h5A, 1'b1);
    n = 1;
    pat8 = 8'h3C;
    exp8 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if ({se8, si8, busy8} !== {1'b1, p[7-k], 1'b1}) begin
        miscompares++;
        $display("FAIL load_bit%0d: got se=%b si=%b busy=%b, want se=1 si=%b busy=1",
                 k, se8, si8, busy8, p[7-k]);
      end
      @(posedge clk); #1; n++;
    end
    vectors++;
    if ({se8, si8, busy8} !== 3'b001) begin
      miscompares++;
      $display("FAIL capture: got se=%b si=%b busy=%b, want 0 0 1", se8, si8, busy8);
    end
    @(posedge clk); #1; n++;
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if ({se8, si8, busy8, done8} !== 4'b1010) begin
        miscompares++;
        $display("FAIL unload%0d: got se=%b si=%b busy=%b done=%b, want 1 0 1 0",
                 k, se8, si8, busy8, done8);
      end
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || n != 18) begin
      miscompares++;
      $display("FAIL done_latency: got done=%b busy=%b at cycle %0d, want done=1 busy=0 at 18",
               done8, busy8, n);
    end
    @(posedge clk); #1;
    vectors++;
    if ({done8, busy8, se8} !== 3'b000) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b busy=%b se=%b, want 000", done8, busy8, se8);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (pass8 !== 1'b1 || resp8 !== 8'h5A) begin
      miscompares++;
      $display("FAIL result_hold: got pass=%b resp=%h, want pass=1 resp=5a", pass8, resp8);
    end
  endtask

  task automatic test_mismatch;
    int n;
    kick8(8'hA5, 8'h5B, 1'b1);
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n != 18) begin
      miscompares++;
      $display("FAIL mismatch_latency: got done at cycle %0d, want 18", n);
    end
    @(posedge clk); #1;
    vectors++;
    if ({done8, busy8, pass8} !== 3'b000 || resp8 !== 8'h5A) begin
      miscompares++;
      $display("FAIL mismatch_after: got done=%b busy=%b pass=%b resp=%h, want 0 0 0 5a",
               done8, busy8, pass8, resp8);
    end
  endtask

  task automatic test_back_to_back;
    int seen;
    int first_at;
    int second_at;
    exp8_t x;
    seen = 0;
    first_at = -1;
    second_at = -1;
    x.resp = 8'h00;
    x.pass = 1'b1;
    sb8.push_back(x);
    sb8.push_back(x);
    pat8 = 8'hFF;
    exp8 = 8'h00;
    start8 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) begin
        seen++;
        if (seen == 1) first_at = i;
        if (seen == 2) second_at = i;
      end
      if (i == 3 || i == 22) begin
        pat8 = 8'h0F;
        exp8 = 8'hFF;
      end
      if (i == 15) begin
        pat8 = 8'hFF;
        exp8 = 8'h00;
      end
      if (i == 37) start8 = 1'b0;
    end
    vectors++;
    if (seen != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d done pulses, want 2", seen);
    end
    vectors++;
    if (first_at != 17 || second_at != 36) begin
      miscompares++;
      $display("FAIL b2b_spacing: got done at edges %0d and %0d, want 17 and 36",
               first_at, second_at);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    kick8(8'h3C, 8'h00, 1'b0);
    n = 1;
    while (n < 13) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (se8 !== 1'b1 || busy8 !== 1'b1 || resp8 !== 8'h06) begin
      miscompares++;
      $display("FAIL unload3_state: got se=%b busy=%b resp=%h, want 1 1 06", se8, busy8, resp8);
    end
    #2;
    nreset = 1'b0;
    #1;
    vectors++;
    if ({se8, si8, busy8, done8, pass8, resp8} !== 13'h0) begin
      miscompares++;
      $display("FAIL async_reset: got se=%b si=%b busy=%b done=%b pass=%b resp=%h, want all 0",
               se8, si8, busy8, done8, pass8, resp8);
    end
    repeat (2) @(posedge clk);
    #3;
    nreset = 1'b1;
    @(posedge clk); #1;
    kick8(8'h00, 8'hFF, 1'b1);
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n != 18 || pass8 !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_seq: got done at cycle %0d pass=%b, want 18 pass=1", n, pass8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_len2;
    int n;
    kick2(2'b10, 2'b10);
    n = 1;
    vectors++;
    if ({se2, si2} !== 2'b11) begin
      miscompares++;
      $display("FAIL len2_bit0: got se=%b si=%b, want 1 1", se2, si2);
    end
    @(posedge clk); #1; n++;
    vectors++;
    if ({se2, si2} !== 2'b10) begin
      miscompares++;
      $display("FAIL len2_bit1: got se=%b si=%b, want 1 0", se2, si2);
    end
    @(posedge clk); #1; n++;
    vectors++;
    if ({se2, si2, busy2} !== 3'b001) begin
      miscompares++;
      $display("FAIL len2_capture: got se=%b si=%b busy=%b, want 0 0 1", se2, si2, busy2);
    end
    while (done2 !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n != 6 || resp2 !== 2'b10 || pass2 !== 1'b1) begin
      miscompares++;
      $display("FAIL len2_done: got cycle %0d resp=%b pass=%b, want 6 10 1", n, resp2, pass2);
    end
    @(posedge clk); #1;
    vectors++;
    if ({done2, busy2} !== 2'b00) begin
      miscompares++;
      $display("FAIL len2_pulse: got done=%b busy=%b, want 0 0", done2, busy2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_capture();
    test_mismatch();
    test_back_to_back();
    test_reset_mid();
    test_len2();
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (sb8.size() != 0 || sb2.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d/%0d results outstanding, want 0/0", sb8.size(), sb2.size());
    end
    vectors++;
    if (dones8 != 5 || dones2 != 1) begin
      miscompares++;
      $display("FAIL done_total: got %0d/%0d done pulses, want 5/1", dones8, dones2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/la_scan_ctrl.md
Name: la_scan_ctrl

Overview:
- Scan-chain test controller: the driving end of the scan interface (si/se/clk) of the library's scan flops.
- Serially loads a test pattern into a chain of LEN scan cells, then issues one functional capture cycle.
- Unloads the captured response from the chain output and compares it against an expected vector.
- Sits in test/BIST wrappers next to the chains it drives, in the same clock domain as the chain.

Parameters:
- LEN, 8: scan chain length in cells; legal range LEN >= 2.
- PROP, "DEFAULT": implementation property passthrough; no functional effect.

Ports:
- clk  input  1  chain/controller clock; all state changes on posedge.
- nreset  input  1  asynchronous active-low reset.
- start  input  1  begin one load/capture/unload sequence; sampled only in IDLE.
- pattern  input  LEN  pattern to load; sampled into a holding register on the accepted start.
- expect  input  LEN  expected response; sampled on the accepted start.
- so  input  1  scan output of the last chain cell.
- se  output  1  scan enable to the chain.
- si  output  1  scan data to the first chain cell.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at sequence end.
- pass  output  1  1 when response == expect; valid from done, held until next accepted start.
- resp  output  LEN  captured response vector; held until next accepted start.

Behaviour:
- Reset (async assert, sync release by flop structure): state=IDLE, se=0, si=0, busy=0, done=0, pass=0, resp=0, counter=0.
- FSM states: IDLE, LOAD, CAPTURE, UNLOAD, DONE.
- IDLE:
  - se=0, si=0.
  - start=1 latches pattern and expect, clears resp, counter=0, next state LOAD.
- LOAD: LEN cycles.
  - se=1; cycle k (k=0..LEN-1) drives si=pattern[LEN-1-k], MSB first.
  - After the LEN-th edge, chain cell j (0=first) holds pattern[j]; next state CAPTURE.
- CAPTURE: exactly 1 cycle.
  - se=0, si=0; chain captures d on this edge.
  - Next state UNLOAD, counter=0.
- UNLOAD: LEN cycles.
  - se=1, si=0 (chain refills with zeros).
  - On each edge, resp <= {resp[LEN-2:0], so}, sampling so as it is before the chain shifts.
  - After LEN edges, resp[LEN-1] is the first bit observed, i.e. the last cell's capture value.
  - Next state DONE.
- DONE: 1 cycle.
  - se=0, done=1, pass=(resp==expect).
  - Then IDLE; busy drops in the same cycle done is high.
- Latency: start accepted at edge 0; done high during cycle 2*LEN+2 after start.
- Counter width: $clog2(LEN+1); must not wrap within a phase.
- start while busy or in DONE: ignored; no queuing.
- pattern/expect changing after the accepted start: no effect on the current sequence.
- Polarity: pattern and expect are values as seen at si/so. Compensation for inverting cells (qn outputs) is the user's responsibility; the controller never inverts.
- nreset mid-sequence: immediate return to reset values. Chain contents are undefined; no done pulse.
- pass/resp retain last result across IDLE; cleared only by reset or a new accepted start.

Test Plan:
- LEN=8, chain model = 8 non-inverting scan flops with d tied to the bitwise complement of the cell's own state; pattern=8'hA5, expect=8'h5A, start pulse -> si sequence 1,0,1,0,0,1,0,1 with se=1 for 8 cycles; se=0 one cycle; 8 unload cycles; resp=8'h5A, pass=1, done pulse exactly 18 cycles after start.
- Same setup, expect=8'h5B -> resp=8'h5A, pass=0, done single-cycle, busy low afterwards.
- start held high continuously for 40 cycles with pattern=8'hFF -> exactly two sequences (starts accepted only in IDLE); done pulses 19 cycles apart; pattern changes mid-sequence ignored.
- nreset asserted during UNLOAD cycle 3 -> se, si, busy, done, pass, resp all 0 asynchronously; after release, new start with pattern=8'h00 and expect=8'hFF completes with pass=1.
- LEN=2, pattern=2'b10, chain d tied to state (capture keeps state), expect=2'b10 -> si=1 then 0, resp=2'b10, pass=1, done 6 cycles after start.
